// File: rtl/i2s_tx.sv
// i2s_tx: serialises 16-bit mono PCM into a Philips I2S frame, same sample on left and right.
// Latency: a sample loaded at a frame boundary starts on sdata one BCLK later (slot 1).
// Backpressure: none; paces the source with sample_req, flags lost samples (overrun) and starved frames (underrun).
module i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic        clear_flags,
  output logic        sample_req,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        overrun,
  output logic        underrun
);

  // A divide-by-one still needs a 1-bit counter to keep the declarations legal.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;
  logic [15:0]   hold;
  logic [15:0]   last;
  logic          hold_full;

  logic          div_wrap;
  logic          fall;
  logic          load;
  logic [4:0]    bit_nxt;
  logic [15:0]   s_sel;
  logic          starve;

  // Event decode and choice of the word loaded at a frame boundary.
  always_comb begin
    div_wrap = (div_cnt == DIV_MAX);
    fall     = div_wrap & bclk;
    bit_nxt  = bit_cnt + 5'd1;
    load     = fall & (bit_nxt == 5'd0);
    starve   = 1'b0;
    if (hold_full) begin
      s_sel = hold;
    end else if (sample_valid) begin
      s_sel = sample_in;
    end else begin
      s_sel  = last;
      starve = 1'b1;
    end
  end

  // Bit-clock divider: toggle bclk every CLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Serial state: slot counter, word select, shifter and the per-frame request pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 5'd31;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      shreg      <= '0;
      last       <= '0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= load;
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= bit_nxt[4];
        // At the load the outgoing bit is the previous right LSB, which gives the one-BCLK delay.
        sdata   <= shreg[31];
        if (load) begin
          shreg <= {s_sel, s_sel};
          last  <= s_sel;
        end else begin
          shreg <= {shreg[30:0], 1'b0};
        end
      end
    end
  end

  // Holding register and sticky flags; a set event beats clear_flags in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (load) begin
        // A bypassed sample is consumed directly, so hold only matters when it was full.
        if (hold_full) begin
          hold_full <= sample_valid;
          if (sample_valid) begin
            hold <= sample_in;
          end
        end
      end else if (sample_valid) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end

      if (load && starve) begin
        underrun <= 1'b1;
      end else if (clear_flags) begin
        underrun <= 1'b0;
      end

      if (!load && sample_valid && hold_full) begin
        overrun <= 1'b1;
      end else if (clear_flags) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame format, request pacing, flags, collisions and mid-frame reset.
// The main DUT runs with CLK_DIV=2; a second instance with CLK_DIV=1 shares the inputs for pacing checks.
module tb_i2s_tx;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        clear_flags;
  logic        sample_req;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        overrun;
  logic        underrun;

  logic        req1;
  logic        bclk1;
  logic        lrclk1;
  logic        sdata1;
  logic        overrun1;
  logic        underrun1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  logic        prev_bclk = 1'b0;
  logic        sd_log[$];
  logic        lr_log[$];
  int          req1_q[$];

  i2s_tx #(.CLK_DIV(2)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .sample_req   (sample_req),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  i2s_tx #(.CLK_DIV(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .sample_req   (req1),
    .bclk         (bclk1),
    .lrclk        (lrclk1),
    .sdata        (sdata1),
    .overrun      (overrun1),
    .underrun     (underrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge 1 is the first rising edge that samples reset low.
  always @(posedge clk) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // Log sdata/lrclk at every observed bclk fall; entry k is slot k mod 32 of frame k/32.
  always @(negedge clk) begin
    if (reset) begin
      sd_log.delete();
      lr_log.delete();
      req1_q.delete();
      prev_bclk = 1'b0;
    end else begin
      if (prev_bclk && !bclk) begin
        sd_log.push_back(sdata);
        lr_log.push_back(lrclk);
      end
      prev_bclk = bclk;
      if (req1) req1_q.push_back(edge_n);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] left_word(input int f);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = sd_log[f*32 + 1 + i];
    return w;
  endfunction

  function automatic logic [15:0] right_word(input int f);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = sd_log[f*32 + 17 + i];
    return w;
  endfunction

  function automatic logic [31:0] lr_word(input int f);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = lr_log[f*32 + i];
    return w;
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    sample_in    = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_state", {26'd0, bclk, lrclk, sdata, sample_req, overrun, underrun}, 32'b010000);
    reset = 1'b0;
  endtask

  task automatic pulse_valid(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_req(output int e);
    e = -1;
    for (int i = 0; i < 1000; i++) begin
      if (sample_req) begin
        e = edge_n;
        break;
      end
      @(negedge clk);
    end
    if (e < 0) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Returns at the falling edge that follows rising edge k.
  task automatic wait_edge(input int k);
    for (int i = 0; i < 2000 && edge_n < k; i++) @(negedge clk);
    check("wait_edge", edge_n, k);
  endtask

  task automatic feed_on_req(input logic [15:0] v, output int e);
    wait_req(e);
    @(negedge clk);
    pulse_valid(v);
  endtask

  int e0, e1, e2, e3, e4, e5;

  initial begin
    reset = 1'b1; sample_valid = 1'b0; clear_flags = 1'b0; sample_in = 16'h0;

    // Basic frame, request loop and underrun.
    do_reset();
    @(negedge clk);
    pulse_valid(16'hA5C3);
    feed_on_req(16'h0001, e0);
    check("first_req_edge", e0, 4);
    feed_on_req(16'h8000, e1);
    check("req_period_1", e1 - e0, 128);
    feed_on_req(16'h7FFF, e2);
    check("req_period_2", e2 - e1, 128);
    feed_on_req(16'h1234, e3);
    check("loop_flags_clear", {30'd0, overrun, underrun}, 32'd0);
    wait_req(e4);
    check("fed_load_flags", {30'd0, overrun, underrun}, 32'd0);
    @(negedge clk);
    wait_req(e5);
    check("underrun_set", {30'd0, overrun, underrun}, 32'b01);
    repeat (80) @(negedge clk);
    check("f0_left",  left_word(0),  16'hA5C3);
    check("f0_right", right_word(0), 16'hA5C3);
    check("f0_lrclk", lr_word(0),    32'hFFFF0000);
    check("f1_left",  left_word(1),  16'h0001);
    check("f1_right", right_word(1), 16'h0001);
    check("f2_left",  left_word(2),  16'h8000);
    check("f2_right", right_word(2), 16'h8000);
    check("f2_lrclk", lr_word(2),    32'hFFFF0000);
    check("f3_left",  left_word(3),  16'h7FFF);
    check("f3_right", right_word(3), 16'h7FFF);
    check("f4_left",  left_word(4),  16'h1234);
    check("f5_resend", left_word(5), 16'h1234);
    check("div1_first_req", req1_q[0], 2);
    check("div1_req_period", req1_q[1] - req1_q[0], 64);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("flags_cleared", {30'd0, overrun, underrun}, 32'd0);

    // Overrun: two samples land in hold within one frame; the later one wins.
    do_reset();
    @(negedge clk);
    pulse_valid(16'h0F0F);
    wait_req(e0);
    @(negedge clk);
    pulse_valid(16'h1111);
    repeat (5) @(negedge clk);
    pulse_valid(16'h2222);
    check("overrun_set", {30'd0, overrun, underrun}, 32'b10);
    wait_req(e1);
    check("ovr_load_edge", e1, 132);
    repeat (80) @(negedge clk);
    check("ovr_f0_left", left_word(0), 16'h0F0F);
    check("ovr_f1_left", left_word(1), 16'h2222);

    // Same-cycle collisions at the load edge.
    do_reset();
    wait_edge(3);
    pulse_valid(16'hBEEF);
    wait_req(e0);
    check("bypass_req_edge", e0, 4);
    check("bypass_no_underrun", {30'd0, overrun, underrun}, 32'd0);
    wait_edge(50);
    pulse_valid(16'hCAFE);
    wait_edge(131);
    pulse_valid(16'hD00D);
    check("collide_no_overrun", {30'd0, overrun, underrun}, 32'd0);
    wait_edge(262);
    check("kept_no_underrun", {30'd0, overrun, underrun}, 32'd0);
    wait_edge(340);
    check("bypass_left",  left_word(0),  16'hBEEF);
    check("bypass_right", right_word(0), 16'hBEEF);
    check("collide_old",  left_word(1),  16'hCAFE);
    check("collide_oldr", right_word(1), 16'hCAFE);
    check("collide_new",  left_word(2),  16'hD00D);

    // Mid-frame reset at slot 9.
    do_reset();
    @(negedge clk);
    pulse_valid(16'hFFFF);
    wait_req(e0);
    @(negedge clk);
    pulse_valid(16'h0001);
    pulse_valid(16'h0002);
    wait_edge(40);
    check("pre_reset_state", {29'd0, sdata, overrun, underrun}, 32'b110);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset", {26'd0, bclk, lrclk, sdata, sample_req, overrun, underrun}, 32'b010000);
    reset = 1'b0;
    wait_req(e1);
    check("post_reset_req_edge", e1, 4);
    check("post_reset_hold_empty", {30'd0, overrun, underrun}, 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serialises 16-bit mono PCM samples into a standard Philips I2S stream (BCLK, LRCLK, SDATA) for an external audio DAC. It sits directly downstream of the sine generator and paces it. Once per stereo frame it pulses `sample_req`, which drives the generator's clock enable, and it accepts the resulting sample via `sample_valid`. The same sample goes out on both the left and right channels.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per BCLK half-period; legal range is ≥1. BCLK = clk / (2·CLK_DIV).

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_in` in 16: two's-complement sample.
- `sample_valid` in 1: one-cycle strobe; `sample_in` is captured in that cycle.
- `clear_flags` in 1: clears the sticky `overrun` and `underrun` flags.
- `sample_req` out 1: one-cycle pulse once per frame, requesting the next sample.
- `bclk` out 1: bit clock, registered.
- `lrclk` out 1: word select; 0 = left, 1 = right; registered.
- `sdata` out 1: serial data, MSB first; registered.
- `overrun` out 1: sticky; a sample was lost.
- `underrun` out 1: sticky; a frame had no fresh sample.

## Operation
Divider:
- `div_cnt` counts 0..CLK_DIV-1 and wraps.
- `bclk` toggles on the edge where `div_cnt`==CLK_DIV-1.
- A 1→0 toggle is a *fall event*. All serial state advances only on fall events.

Bit counter:
- `bit_cnt` is 5 bits, 0..31, and wraps. On each fall event it becomes n = `bit_cnt`+1.
- `lrclk` <= n[4]: left for slots 0..15, right for slots 16..31.

Shifter:
- `shreg` is 32 bits.
- On a fall event with n≠0: `sdata` <= `shreg`[31]; `shreg` <= `shreg`<<1.
- On a fall event with n==0: `sdata` <= `shreg`[31] (the previous frame's right-channel LSB, giving the I2S one-BCLK delay); `shreg` <= {S,S}; `sample_req` pulses for one cycle.

Bit sequence per frame:
- Left MSB appears at slot 1, left LSB at slot 16.
- Right MSB appears at slot 17, right LSB at slot 0 of the next frame.

Holding register and selection of S:
- `hold` is 16 bits, with a `hold_full` flag.
- `sample_valid` writes `hold` and sets `hold_full`.
- At load with `hold_full`=1: S = `hold`; `hold_full` clears, unless `sample_valid` arrives in the same cycle, in which case the new value is stored and `hold_full` stays 1.
- At load with `hold_full`=0 and `sample_valid`=1 in the same cycle: S = `sample_in` (bypass); `hold_full` stays 0; no underrun.
- At load with `hold_full`=0 and no `sample_valid`: S = `last` (the previously loaded S); `underrun` <= 1.
- `last` <= S on every load.

Flags:
- `overrun` <= 1 when `sample_valid` arrives while `hold_full`=1 and no load occurs that cycle. The new value overwrites `hold`.
- `clear_flags` clears both flags. A set event in the same cycle wins.

Reset values:
- `bclk`=0, `lrclk`=1, `sdata`=0, `sample_req`=0, `overrun`=0, `underrun`=0.
- `div_cnt`=0, `bit_cnt`=31, `shreg`=0, `hold`=0, `hold_full`=0, `last`=0.
- Reset mid-frame aborts the frame immediately. Streaming restarts from these values; no partial word is flushed.

## Timing
- First fall event: rising edge E = 2·CLK_DIV edges after the first cycle with `reset` low. That edge performs the first load.
- `sample_req` is high for exactly the clk cycle after each load edge.
- Frame period is 64·CLK_DIV clk cycles. The `sample_req` spacing is identical.
- `lrclk` and `sdata` change only on the clk edge that drives `bclk` low. DAC sampling on BCLK rising edges sees CLK_DIV cycles of setup.
- A sample must arrive within 64·CLK_DIV-1 cycles after `sample_req` to avoid underrun. The generator path (`sample_req`→clk_en, with its output registered one cycle later) meets this for any CLK_DIV≥1.
- CLK_DIV=1: `bclk` toggles every cycle; fall events occur every 2 cycles. All rules above still hold.

## Test plan
- **Reset / basic frame.** CLK_DIV=2; drive `sample_valid` with `sample_in`=0xA5C3 one cycle after reset release. Expected:
  - first `sample_req` at edge 4;
  - `sdata` over slots 1..16 = 1010_0101_1100_0011 with `lrclk`=0;
  - slots 17..31 + next slot 0 repeat the same bits with `lrclk`=1;
  - no flags set.
- **Request loop.** Feed `sample_valid` = `sample_req` delayed by 1, with samples 0x0001, 0x8000, 0x7FFF. Expected: each word appears in consecutive frames; `sample_req` period = 128 cycles; `underrun`=0.
- **Underrun.** Skip one sample after 0x1234. Expected: the next frame re-sends 0x1234 and `underrun`=1. `clear_flags` then returns it to 0.
- **Overrun.** Two `sample_valid` pulses (0x1111 then 0x2222) within one frame. Expected: `overrun`=1 and 0x2222 is transmitted.
- **Same-cycle collisions.**
  - `sample_valid` on the load edge with `hold` empty → bypass: the value is sent this frame, no underrun.
  - `sample_valid` on the load edge with `hold` full → the old `hold` is sent and the new value is kept for the next frame; no overrun.
- **Mid-frame reset.** Assert `reset` at slot 9. Expected: the next cycle shows `bclk`=0, `lrclk`=1, `sdata`=0, both flags 0; the first post-reset load occurs 2·CLK_DIV edges after release.
